// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I(+M) controller: sequences FETCH/DECODE/EXEC/MEM/WB with handshaked
// instruction/data memories, illegal-instruction and bus-timeout traps, and an optional
// multi-cycle multiply wait state.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   instr                       IR contents, valid from DECODE onward
//   imem_req/imem_ready         instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready data access handshake (we: 1 store, 0 load)
//   branch_taken                comparator result, sampled in EXEC
//   ir_load, pc_write, pc_sel   IR/PC update strobes and PC source
//   reg_write, wb_sel           register write enable and write-back source
//   ALUsel, alu_a_sel,
//   alu_b_sel, signEx_sel       ALU operation, operand selects, immediate type
//   rd_sel, wr_sel, branchType  load type, store type, branch condition
//   mul_start                   one-cycle multiplier start pulse
//   trap, trap_cause, state     trap strobe, registered cause, FSM state for debug
module multicycle_controller #(
    parameter bit          EN_M    = 1'b1,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [3:0]  ALUsel,
    output logic [2:0]  signEx_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  rd_sel,
    output logic [1:0]  wr_sel,
    output logic [2:0]  branchType,
    output logic        mul_start,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StMulw   = 3'd5,
        StTrap   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu, ClsAluImm, ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore, ClsMul
    } cls_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
    localparam logic [7:0] MulLast  = 8'(MUL_LAT - 1);

    state_e     state_q;
    logic [7:0] wait_q;
    logic [1:0] cause_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;
    cls_e       cls;
    logic       legal;
    logic       alt;
    logic [3:0] alu_op;
    logic [2:0] ld_type;
    logic [1:0] st_type;
    logic [2:0] br_type;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    // funct7[5] selects sub/sra, but only register ops use it for funct3=0 (addi has imm there)
    assign alt = funct7[5] && ((opcode == OpReg) || (funct3 == 3'd5));

    always_comb begin
        cls   = ClsAlu;
        legal = 1'b0;
        case (opcode)
            OpLui:    begin cls = ClsLui;    legal = 1'b1; end
            OpAuipc:  begin cls = ClsAuipc;  legal = 1'b1; end
            OpJal:    begin cls = ClsJal;    legal = 1'b1; end
            OpJalr:   begin cls = ClsJalr;   legal = (funct3 == 3'd0); end
            OpBranch: begin cls = ClsBranch; legal = (funct3 != 3'd2) && (funct3 != 3'd3); end
            OpLoad: begin
                cls   = ClsLoad;
                legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OpStore:  begin cls = ClsStore;  legal = (funct3 < 3'd3); end
            OpImm: begin
                cls = ClsAluImm;
                case (funct3)
                    3'd1:    legal = (funct7 == 7'b0000000);
                    3'd5:    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OpReg: begin
                if (funct7 == 7'b0000001) begin
                    cls   = ClsMul;
                    legal = EN_M && !funct3[2];  // MUL..MULHU only; DIV/REM never
                end else if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                end else if (funct7 == 7'b0100000) begin
                    legal = (funct3 == 3'd0) || (funct3 == 3'd5);
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_op  = 4'd0;
        ld_type = 3'd0;
        st_type = 2'd0;
        case (funct3)
            3'd0:    alu_op = alt ? 4'd1 : 4'd0;
            3'd1:    alu_op = 4'd2;
            3'd2:    alu_op = 4'd3;
            3'd3:    alu_op = 4'd4;
            3'd4:    alu_op = 4'd5;
            3'd5:    alu_op = alt ? 4'd7 : 4'd6;
            3'd6:    alu_op = 4'd8;
            default: alu_op = 4'd9;
        endcase
        case (funct3)
            3'd1:    ld_type = 3'd1;
            3'd2:    ld_type = 3'd2;
            3'd4:    ld_type = 3'd3;
            3'd5:    ld_type = 3'd4;
            default: ld_type = 3'd0;
        endcase
        case (funct3)
            3'd0:    st_type = 2'd1;
            3'd1:    st_type = 2'd2;
            default: st_type = 2'd0;
        endcase
    end

    // beq,bne map straight through; blt..bgeu (funct3 4..7) map to 2..5
    assign br_type = funct3[2] ? (funct3 - 3'd2) : funct3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            wait_q  <= 8'd0;
            cause_q <= 2'd0;
        end else begin
            wait_q <= 8'd0;
            case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        state_q <= StDecode;
                    end else if (wait_q == WaitLast) begin
                        state_q <= StTrap;
                        cause_q <= 2'd2;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDecode: begin
                    if (legal) begin
                        state_q <= StExec;
                    end else begin
                        state_q <= StTrap;
                        cause_q <= 2'd1;
                    end
                end
                StExec: begin
                    case (cls)
                        ClsBranch:         state_q <= StFetch;
                        ClsLoad, ClsStore: state_q <= StMem;
                        ClsMul:            state_q <= StMulw;
                        default:           state_q <= StWb;
                    endcase
                end
                StMem: begin
                    if (dmem_ready) begin
                        state_q <= (cls == ClsStore) ? StFetch : StWb;
                    end else if (wait_q == WaitLast) begin
                        state_q <= StTrap;
                        cause_q <= 2'd2;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StMulw: begin
                    if (wait_q == MulLast) begin
                        state_q <= StWb;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;

    // Gated by rst_n so every strobe drops the moment reset asserts
    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 2'd0;
        reg_write  = 1'b0;
        ALUsel     = 4'd0;
        signEx_sel = 3'd0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        wb_sel     = 2'd0;
        rd_sel     = 3'd0;
        wr_sel     = 2'd0;
        branchType = 3'd7;
        mul_start  = 1'b0;
        trap       = 1'b0;
        if (rst_n) begin
            case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                StExec: begin
                    case (cls)
                        ClsAlu:    ALUsel = alu_op;
                        ClsAluImm: begin ALUsel = alu_op; alu_b_sel = 1'b1; end
                        ClsLui:    begin ALUsel = 4'hA; alu_b_sel = 1'b1; signEx_sel = 3'd2; end
                        ClsAuipc: begin
                            alu_a_sel  = 1'b1;
                            alu_b_sel  = 1'b1;
                            signEx_sel = 3'd2;
                        end
                        ClsJal:    begin branchType = 3'd6; signEx_sel = 3'd3; end
                        ClsJalr:   begin branchType = 3'd6; alu_b_sel = 1'b1; end
                        ClsBranch: begin
                            branchType = br_type;
                            signEx_sel = 3'd1;
                            pc_write   = 1'b1;
                            pc_sel     = branch_taken ? 2'd1 : 2'd0;
                        end
                        ClsLoad:   alu_b_sel = 1'b1;
                        ClsStore:  begin alu_b_sel = 1'b1; signEx_sel = 3'd4; end
                        default:   mul_start = 1'b1;
                    endcase
                end
                StMem: begin
                    dmem_req = 1'b1;
                    if (cls == ClsStore) begin
                        dmem_we  = 1'b1;
                        wr_sel   = st_type;
                        pc_write = dmem_ready;
                    end else begin
                        rd_sel = ld_type;
                    end
                end
                StWb: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    case (cls)
                        ClsLoad: wb_sel = 2'd1;
                        ClsMul:  wb_sel = 2'd3;
                        ClsJal:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
                        ClsJalr: begin wb_sel = 2'd2; pc_sel = 2'd2; end
                        default: wb_sel = 2'd0;
                    endcase
                end
                StTrap: begin
                    trap     = 1'b1;
                    pc_write = 1'b1;
                    pc_sel   = 2'd3;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle decoder/controller of the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, so instruction and data memories are handshaked with wait states.
- Adds illegal-instruction and bus-timeout traps, plus an optional multi-cycle multiply (RV32M MUL/MULH/MULHSU/MULHU).
- Drives the shared datapath (PC, IR, regfile, ALU, LSU) with control strobes.

Parameters:
- EN_M, 1, 1 enables MUL* (funct7=0000001, funct3 0-3); 0 makes them illegal. DIV/REM are always illegal.
- MUL_LAT, 4, cycles spent in MULW (>=1).
- TIMEOUT, 255, max wait cycles on imem/dmem before bus-error trap (8-bit counter, >=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IR contents; valid from DECODE onward.
- imem_req  out  1  fetch request.
- imem_ready  in  1  fetch data valid.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load.
- dmem_ready  in  1  data access complete.
- branch_taken  in  1  comparator result; valid in EXEC.
- ir_load  out  1  latch instruction into IR.
- pc_write  out  1  update PC.
- pc_sel  out  2  0 pc+4, 1 pc-relative target, 2 jalr target, 3 trap vector.
- reg_write  out  1  regfile write enable.
- ALUsel  out  4  0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,A pass-B.
- signEx_sel  out  3  immediate type: 0 I,1 B,2 U,3 J,4 S.
- alu_a_sel  out  1  0 rs1, 1 pc.
- alu_b_sel  out  1  0 rs2, 1 imm.
- wb_sel  out  2  0 ALU, 1 load data, 2 pc+4, 3 multiplier.
- rd_sel  out  3  load type: 0 lb,1 lh,2 lw,3 lbu,4 lhu.
- wr_sel  out  2  store type: 0 sw,1 sb,2 sh.
- branchType  out  3  0 beq,1 bne,2 blt,3 bge,4 bltu,5 bgeu,6 jump,7 none.
- mul_start  out  1  one-cycle multiplier start pulse.
- trap  out  1  trap taken.
- trap_cause  out  2  0 none, 1 illegal instruction, 2 bus timeout.
- state  out  3  FSM state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULW=5, TRAP=6.
- Reset (rst_n low, asynchronous): state=FETCH, wait counter=0, trap_cause=0. All strobes deassert immediately, including a mid-MEM dmem_req. First cycle after release: imem_req=1.
- Outputs are combinational from state, the registered trap_cause and instr. Whenever not in use: branchType=7, all strobes 0, selects 0.
- FETCH: imem_req=1 until imem_ready. ir_load=imem_ready. On ready go to DECODE.
- DECODE: classify opcode/funct3/funct7.
  - Unknown opcode, bad funct7 or unsupported funct3 go to TRAP with cause=1.
  - Otherwise go to EXEC.
- EXEC: ALU operands and ALUsel driven per type.
  - Branch: pc_write=1; pc_sel=1 if branch_taken else 0. Then FETCH.
  - Load/store: go to MEM.
  - MUL: mul_start=1, go to MULW.
  - All others: go to WB.
- MEM: dmem_req=1 with dmem_we, rd_sel and wr_sel held stable until dmem_ready.
  - Store: pc_write=1 (pc_sel=0) on the ready cycle, then FETCH.
  - Load: go to WB.
- MULW: counter runs 0..MUL_LAT-1, then WB with wb_sel=3.
- WB: reg_write=1 and pc_write=1, both for exactly one cycle. JAL: pc_sel=1, wb_sel=2. JALR: pc_sel=2, wb_sel=2. Otherwise pc_sel=0.
- LUI: signEx_sel=2, ALUsel=A. AUIPC: alu_a_sel=1, signEx_sel=2, ALUsel=0.
- pc_write pulses exactly once per retired instruction.
- Zero-wait latency:
  - branch 3 cycles;
  - ALU/jump/store 4;
  - load 5;
  - MUL 4+MUL_LAT.
- Wait counter: cleared on every state entry; increments each FETCH/MEM cycle without ready. At TIMEOUT go to TRAP with cause=2. Ready arriving on the TIMEOUT cycle wins, so no trap.
- TRAP: one cycle with trap=1, pc_write=1, pc_sel=3, reg_write=0. Next state FETCH. trap_cause stays registered until the next TRAP or reset.

Test Plan:
- add x3,x1,x2 with zero-wait memory -> states 0,1,2,4; reg_write and pc_write in cycle 4 only; ALUsel=0, alu_b_sel=0, wb_sel=0.
- lhu with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, rd_sel=4, dmem_we=0; WB then drives wb_sel=1 with one reg_write pulse.
- beq, branch_taken=1 -> 3 cycles, pc_sel=1 with pc_write in EXEC, branchType=0, reg_write never asserted.
- mul with EN_M=1, MUL_LAT=4 -> mul_start pulses once, 4 MULW cycles, then WB with wb_sel=3. Same instruction with EN_M=0 -> TRAP, cause=1, pc_sel=3.
- imem_ready held low, TIMEOUT=255 -> TRAP with trap_cause=2 after 255 waits. Ready on exactly the 255th wait cycle -> DECODE, no trap.
- rst_n pulsed low mid-MEM -> dmem_req drops asynchronously; after release state=0 and imem_req=1.
